// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: default payload widths,
// the bubble instruction, instruction-type codes and the stage payload layout.
package riscv_pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_INST_W = 32;
   localparam int DEF_TYPE_W = 5;
   localparam int DEF_CNT_W  = 16;

   // Instruction word carried by an empty stage; all-zero unless a stage overrides it.
   localparam logic [DEF_INST_W-1:0] DEF_BUBBLE_INST = 32'd0;

   typedef enum logic [DEF_TYPE_W-1:0] {
      TYPE_NONE   = 5'd0,
      TYPE_ALU    = 5'd1,
      TYPE_LOAD   = 5'd2,
      TYPE_STORE  = 5'd3,
      TYPE_BRANCH = 5'd4,
      TYPE_JUMP   = 5'd5
   } inst_type_e;

   // Field order matches the {data, inst, type} concatenation used by the stage register.
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_INST_W-1:0] inst;
      logic [DEF_TYPE_W-1:0] itype;
   } stage_payload_t;

   function automatic stage_payload_t bubble_payload();
      stage_payload_t p;
      p.data  = '0;
      p.inst  = DEF_BUBBLE_INST;
      p.itype = '0;
      return p;
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot of a pipeline-stage register: a payload register plus its
// valid bit. Clearing returns the payload to the bubble value so an empty slot
// never shows stale data.
module pipe_skid_slot #(
   parameter int               PAY_W  = 69,
   parameter logic [PAY_W-1:0] BUBBLE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic [PAY_W-1:0] pay_in,
   output logic             valid,
   output logic [PAY_W-1:0] pay
);

   // Clear wins over load so a flush can never be overridden by a same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pay   <= BUBBLE;
      end else if (clear) begin
         valid <= 1'b0;
         pay   <= BUBBLE;
      end else if (load) begin
         valid <= 1'b1;
         pay   <= pay_in;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake. MAIN drives the outputs,
// SKID catches the one entry that arrives while MAIN is stalled, so upstream
// sees a registered ready and the stage still streams one entry per cycle.
module pipe_stage_reg
   import riscv_pipe_pkg::*;
#(
   parameter int                DATA_W      = DEF_DATA_W,
   parameter int                INST_W      = DEF_INST_W,
   parameter int                TYPE_W      = DEF_TYPE_W,
   parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(DEF_BUBBLE_INST),
   parameter int                CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [INST_W-1:0] inst_in,
   input  logic [TYPE_W-1:0] type_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [INST_W-1:0] inst_out,
   output logic [TYPE_W-1:0] type_out,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int               PAY_W      = DATA_W + INST_W + TYPE_W;
   localparam logic [PAY_W-1:0] BUBBLE_PAY = {{DATA_W{1'b0}}, BUBBLE_INST, {TYPE_W{1'b0}}};

   logic             main_valid, skid_valid;
   logic [PAY_W-1:0] main_pay, skid_pay, in_pay, main_src;
   logic             main_load, main_clear, skid_load, skid_clear;
   logic             accept, issue;

   assign in_pay = {data_in, inst_in, type_in};
   assign accept = in_valid & in_ready;
   assign issue  = main_valid & out_ready;

   // Ready depends only on the SKID valid flop, so it is a registered signal.
   assign in_ready = ~skid_valid;

   // Slot control: flush first, then drain SKID into MAIN, otherwise accept into
   // whichever slot keeps arrival order.
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_src   = in_pay;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (skid_valid) begin
         if (issue) begin
            main_load  = 1'b1;
            main_src   = skid_pay;
            skid_clear = 1'b1;
         end
      end else if (accept) begin
         if (!main_valid || issue) begin
            main_load = 1'b1;
         end else begin
            skid_load = 1'b1;
         end
      end else if (issue) begin
         main_clear = 1'b1;
      end
   end

   pipe_skid_slot #(.PAY_W(PAY_W), .BUBBLE(BUBBLE_PAY)) u_main (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (main_load),
      .clear  (main_clear),
      .pay_in (main_src),
      .valid  (main_valid),
      .pay    (main_pay)
   );

   pipe_skid_slot #(.PAY_W(PAY_W), .BUBBLE(BUBBLE_PAY)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .clear  (skid_clear),
      .pay_in (in_pay),
      .valid  (skid_valid),
      .pay    (skid_pay)
   );

   assign out_valid                      = main_valid;
   assign {data_out, inst_out, type_out} = main_pay;
   assign occupancy                      = {1'b0, main_valid} + {1'b0, skid_valid};

   // Count cycles where the held entry is blocked downstream; saturate, survive flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a FIFO-of-capacity-2 reference model
// held as a queue, directed scenarios and a long randomized run.
module tb_pipe_stage_reg;
   import riscv_pipe_pkg::*;

   localparam int          DW  = 32;
   localparam int          IW  = 32;
   localparam int          TW  = 5;
   localparam int          CW  = 4;
   localparam int          PW  = DW + IW + TW;
   localparam logic [31:0] BUB = 32'h0000_0013;
   localparam int          SAT = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [IW-1:0] inst_in = '0;
   logic [TW-1:0] type_in = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] data_out;
   logic [IW-1:0] inst_out;
   logic [TW-1:0] type_out;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;

   logic [PW-1:0] exp_q[$];
   int            m_stall = 0;
   bit            mon_en = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            n_issued = 0;

   pipe_stage_reg #(
      .DATA_W(DW), .INST_W(IW), .TYPE_W(TW), .BUBBLE_INST(BUB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .inst_in(inst_in), .type_in(type_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .inst_out(inst_out), .type_out(type_out),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, then record what the
   // upstream side handed over once that cycle's edge has happened.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic fl,
                                input logic ordy, output logic acc);
      in_valid  = v;
      data_in   = d;
      inst_in   = $urandom;
      type_in   = TW'($urandom);
      flush     = fl;
      out_ready = ordy;
      acc       = v && in_ready && !fl;
      @(posedge clk);
      #2;
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back({d, inst_in, type_in});
   endtask

   task automatic doReset();
      mon_en    = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      inst_in   = '0;
      type_in   = '0;
      exp_q.delete();
      m_stall = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   // Monitor: compare the DUT against the queue model mid-cycle, pop on issue.
   always @(negedge clk) begin
      bit had;
      if (mon_en) begin
         had = (exp_q.size() > 0);
         checkOutput("occupancy", occupancy, exp_q.size());
         checkOutput("out_valid", out_valid, had);
         checkOutput("in_ready", in_ready, exp_q.size() < 2);
         checkOutput("stall_cnt", stall_cnt, m_stall);
         if (!had) checkOutput("bubble", {data_out, inst_out, type_out}, {32'd0, BUB, 5'd0});
         else      checkOutput("payload", {data_out, inst_out, type_out}, exp_q[0]);
         if (had && out_ready && !flush) begin
            void'(exp_q.pop_front());
            n_issued++;
         end
         if (had && !out_ready && m_stall < SAT) m_stall++;
      end
   end

   initial begin
      logic acc;
      int   base;

      // 1: asynchronous reset while both slots are full
      doReset();
      checkOutput("t1 reset in_ready", in_ready, 1);
      applyStimulus(1, 32'd1, 0, 0, acc);
      applyStimulus(1, 32'd2, 0, 0, acc);
      checkOutput("t1 full occupancy", occupancy, 2);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      checkOutput("t1 out_valid", out_valid, 0);
      checkOutput("t1 inst_out", inst_out, BUB);
      checkOutput("t1 occupancy", occupancy, 0);
      checkOutput("t1 in_ready", in_ready, 1);
      checkOutput("t1 stall_cnt", stall_cnt, 0);

      // 2: streaming at full rate
      doReset();
      base = n_issued;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1, DW'(i), 0, 1, acc);
         checkOutput("t2 accept", acc, 1);
         checkOutput("t2 data_out", data_out, i);
      end
      repeat (2) applyStimulus(0, '0, 0, 1, acc);
      checkOutput("t2 issued", n_issued - base, 8);
      checkOutput("t2 stall_cnt", stall_cnt, 0);

      // 3: back-pressure fills SKID, release drains in order
      doReset();
      base = n_issued;
      applyStimulus(1, 32'd10, 0, 1, acc);
      applyStimulus(1, 32'd11, 0, 0, acc);
      applyStimulus(1, 32'd12, 0, 0, acc);
      applyStimulus(1, 32'd12, 0, 0, acc);
      checkOutput("t3 data_out", data_out, 10);
      checkOutput("t3 occupancy", occupancy, 2);
      checkOutput("t3 in_ready", in_ready, 0);
      checkOutput("t3 stall_cnt", stall_cnt, 3);
      acc = 1'b0;
      for (int k = 0; k < 4 && !acc; k++) applyStimulus(1, 32'd12, 0, 1, acc);
      checkOutput("t3 12 accepted", acc, 1);
      repeat (3) applyStimulus(0, '0, 0, 1, acc);
      checkOutput("t3 issued", n_issued - base, 3);

      // 4: flush with both slots full and a new input offered
      doReset();
      applyStimulus(1, 32'd20, 0, 0, acc);
      applyStimulus(1, 32'd21, 0, 0, acc);
      applyStimulus(1, 32'd22, 0, 0, acc);
      checkOutput("t4 pre occupancy", occupancy, 2);
      applyStimulus(1, 32'd99, 1, 1, acc);
      checkOutput("t4 out_valid", out_valid, 0);
      checkOutput("t4 occupancy", occupancy, 0);
      checkOutput("t4 in_ready", in_ready, 1);
      checkOutput("t4 stall_cnt", stall_cnt, 2);
      checkOutput("t4 bubble inst", inst_out, BUB);
      applyStimulus(0, '0, 0, 1, acc);
      checkOutput("t4 dropped", out_valid, 0);

      // 5: stall counter saturation
      doReset();
      applyStimulus(1, 32'd30, 0, 0, acc);
      repeat (20) applyStimulus(0, '0, 0, 0, acc);
      checkOutput("t5 stall_cnt", stall_cnt, SAT);
      applyStimulus(0, '0, 0, 1, acc);
      checkOutput("t5 kept after drain", stall_cnt, SAT);

      // 6: randomized traffic with occasional flush
      doReset();
      base = n_issued;
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), DW'(1000 + i),
                       1'($urandom_range(0, 63) == 0),
                       1'(($urandom % 4) != 0), acc);
      end
      repeat (4) applyStimulus(0, '0, 0, 1, acc);
      checkOutput("t6 drained", exp_q.size(), 0);
      checkOutput("t6 out_valid", out_valid, 0);
      checkOutput("t6 traffic", (n_issued - base) > 1000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
